fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_ALIGN_CHK_EN (optional) adds a sticky misaligned-redirect fault output.
package fetch_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned ENTRY_PC_W    = 32;
  localparam int unsigned ENTRY_INSTR_W = 32;

  localparam logic [ENTRY_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO with flush; head entry is visible on data_o.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && !flush_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: only entries below count_q are ever consumed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the fetch PC, issues imem requests under a credit limit and
// buffers responses for decode. FETCH_ALIGN_CHK_EN adds the fetch_fault output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              SIZE      = 32,
  parameter int              INSTR_W   = 32,
  parameter logic [SIZE-1:0] RESET_VEC = '0,
  parameter int              DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [SIZE-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [SIZE-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [SIZE-1:0]    if_pc
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic               fetch_fault
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e          state_q, state_d;
  logic [SIZE-1:0]       pc_q, pc_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         pcq_count;
  logic [CW-1:0]         ibuf_count;
  logic [SIZE-1:0]       pcq_head;
  logic [SIZE+INSTR_W-1:0] ibuf_head;
  logic [CW:0]           credit_used;
  logic                  req_fire;
  logic                  resp_keep;
  logic                  req_inhibit;

  // The in-flight PC queue occupancy is the outstanding-request count.
  assign credit_used    = {1'b0, pcq_count} + {1'b0, ibuf_count};
  assign imem_req_valid = (state_q == RUN) && !redirect_valid && !req_inhibit
                          && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && !redirect_valid && (state_q != FLUSH);

  assign if_valid = (ibuf_count != '0);
  assign if_instr = if_valid ? ibuf_head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign if_pc    = if_valid ? ibuf_head[SIZE+INSTR_W-1:INSTR_W] : '0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is already dropped, so it is not counted.
      pc_d      = {redirect_pc[SIZE-1:2], 2'b00};
      discard_d = pcq_count - CW'(imem_resp_valid);
      state_d   = (discard_d == '0) ? RUN : FLUSH;
    end else begin
      pc_d = req_fire ? pc_q + SIZE'(WORD_BYTES) : pc_q;
      case (state_q)
        HOLD:  state_d = RUN;
        RUN:   state_d = RUN;
        FLUSH: begin
          discard_d = discard_q - CW'(imem_resp_valid);
          state_d   = (discard_d == '0) ? RUN : FLUSH;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      pc_q      <= RESET_VEC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
  assign req_inhibit = fault_q;
`else
  logic unused_align_bits;
  assign unused_align_bits = ^redirect_pc[1:0];
  assign req_inhibit       = 1'b0;
`endif

  fetch_buf #(.W(SIZE), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (imem_resp_valid),
    .data_o  (pcq_head),
    .count_o (pcq_count)
  );

  fetch_buf #(.W(SIZE + INSTR_W), .DEPTH(DEPTH)) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (resp_keep),
    .data_i  ({pcq_head, imem_resp_data}),
    .pop_i   (if_valid && if_ready),
    .data_o  (ibuf_head),
    .count_o (ibuf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of stream phases plus hand-written
// redirect / wrap / alignment / async-reset sequences, with a delivery scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.SIZE(32), .INSTR_W(32), .RESET_VEC(32'h0), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    string       name;
    bit          if_rdy;
    bit          mem_rdy;
    int          lat;
    int          cycles;
    int          issues;
    bit          req_v;
    logic [31:0] addr;
    bit          if_v;
    logic [31:0] pc;
  } phase_t;

  mem_req_t     mem_q[$];
  fetch_entry_t exp_q[$];
  phase_t       ph[5];
  int           n_vec = 0;
  int           n_miss = 0;
  int           cyc = 0;
  int           mem_lat = 1;
  int           n_issued = 0;
  logic [31:0]  exp_addr = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor at the negedge, then advance one clock and drive the memory response.
  task automatic cycle();
    fetch_entry_t e;
    @(negedge clk);
    if (redirect_valid) begin
      chk1("redirect_gates_req", imem_req_valid, 1'b0);
      exp_q.delete();
      exp_addr = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("issue_addr", imem_req_addr, exp_addr);
        mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        exp_q.push_back('{pc: imem_req_addr, instr: mem_data(imem_req_addr)});
        exp_addr = exp_addr + 32'd4;
        n_issued++;
      end
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_delivery_pc", if_pc, 32'hDEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", if_pc, e.pc);
          chk("deliver_instr", if_instr, e.instr);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    while ((mem_q.size() != 0 || imem_resp_valid || exp_q.size() != 0) && n < 50) begin
      cycle();
      n++;
    end
    n_vec++;
    if (n >= 50) begin
      n_miss++;
      $display("FAIL drain: pipeline still busy after %0d cycles, want empty", n);
    end
  endtask

  initial begin
    //        name          if_rdy mem_rdy lat cyc iss req_v addr          if_v pc
    ph[0] = '{"stall_fill",  1'b0, 1'b1,  1,  3,  2,  1'b0, 32'h0,        1'b1, 32'h0};
    ph[1] = '{"stall_hold",  1'b0, 1'b1,  1,  7,  0,  1'b0, 32'h0,        1'b1, 32'h0};
    ph[2] = '{"release",     1'b1, 1'b1,  1,  6,  4,  1'b0, 32'h0,        1'b1, 32'h10};
    ph[3] = '{"mem_stall",   1'b1, 1'b0,  1,  4,  0,  1'b1, 32'h18,       1'b0, 32'h0};
    ph[4] = '{"lat2_stream", 1'b1, 1'b1,  2,  6,  4,  1'b0, 32'h0,        1'b0, 32'h0};

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk1("rst_fetch_fault", fetch_fault, 1'b0);
`endif
    if_ready = ph[0].if_rdy;
    rst_n = 1'b1;
    cyc = 0;
    #1;
    chk1("hold_no_req", imem_req_valid, 1'b0);

    for (int p = 0; p < 5; p++) begin
      int n0;
      if_ready       = ph[p].if_rdy;
      imem_req_ready = ph[p].mem_rdy;
      mem_lat        = ph[p].lat;
      n0 = n_issued;
      repeat (ph[p].cycles) cycle();
      #1;
      chk({ph[p].name, "_issues"}, n_issued - n0, ph[p].issues);
      chk1({ph[p].name, "_req_valid"}, imem_req_valid, ph[p].req_v);
      if (ph[p].req_v) chk({ph[p].name, "_req_addr"}, imem_req_addr, ph[p].addr);
      chk1({ph[p].name, "_if_valid"}, if_valid, ph[p].if_v);
      if (ph[p].if_v) chk({ph[p].name, "_if_pc"}, if_pc, ph[p].pc);
    end

    // Redirect with two requests outstanding: both responses dropped in FLUSH.
    drain();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    cycle();
    cycle();
    chk("two_outstanding", mem_q.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    mem_lat = 1;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk1("flush1_if_valid", if_valid, 1'b0);
    chk1("flush1_req_valid", imem_req_valid, 1'b0);
    cycle();
    #1;
    chk1("flush2_if_valid", if_valid, 1'b0);
    chk1("flush2_req_valid", imem_req_valid, 1'b0);
    cycle();
    #1;
    chk1("post_flush_req_valid", imem_req_valid, 1'b1);
    chk("post_flush_req_addr", imem_req_addr, 32'h100);
    cycle();
    cycle();
    #1;
    chk1("post_flush_if_valid", if_valid, 1'b1);
    chk("post_flush_if_pc", if_pc, 32'h100);

    // Redirect coinciding with a response and a pop.
    drain();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    cycle();
    cycle();
    chk1("coinc_resp_present", imem_resp_valid, 1'b1);
    chk1("coinc_pop_present", if_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk1("coinc_buf_empty", if_valid, 1'b0);
    chk1("coinc_req_valid", imem_req_valid, 1'b1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);

    // Sequential fetch across the top of the address space.
    drain();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk1("wrap_req_valid0", imem_req_valid, 1'b1);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    #1;
    chk1("wrap_req_valid1", imem_req_valid, 1'b1);
    chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
    repeat (4) cycle();

    // Misaligned redirect target.
    drain();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHK_EN
    chk1("align_fault_set", fetch_fault, 1'b1);
    chk1("align_req_blocked", imem_req_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      #1;
      chk1("align_fault_sticky", fetch_fault, 1'b1);
      chk1("align_req_still_blocked", imem_req_valid, 1'b0);
    end
`else
    chk1("align_req_valid", imem_req_valid, 1'b1);
    chk("align_req_addr", imem_req_addr, 32'h100);
    repeat (4) cycle();
`endif

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_if_valid", if_valid, 1'b0);
    chk1("async_rst_req_valid", imem_req_valid, 1'b0);
`ifdef FETCH_ALIGN_CHK_EN
    chk1("async_rst_fault", fetch_fault, 1'b0);
`endif
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
